// File: rtl/shift_arbiter_pkg.sv
// Shared types for the shift issue arbiter:
// shifter op encoding, requester id, port count and shifter latency.
package shift_arbiter_pkg;

  typedef enum logic [1:0] {
    OP0 = 2'd0,
    OP1 = 2'd1,
    OP2 = 2'd2,
    OP3 = 2'd3
  } instruction_type;

  typedef logic req_id_t;

  localparam int NREQ      = 2;
  localparam int SHIFT_LAT = 1;

endpackage

// File: rtl/rr_arb2.sv
// Two-request round-robin arbiter: combinational grant,
// registered pointer naming the favoured port on a tie.
module rr_arb2
  import shift_arbiter_pkg::*;
(
  input  logic            clk,
  input  logic            rstn,
  input  logic [NREQ-1:0] req_i,
  output logic [NREQ-1:0] gnt_o
);

  req_id_t ptr_q;
  req_id_t ptr_d;

  always_comb begin
    gnt_o = '0;
    unique case (1'b1)
      (req_i[0] && (!req_i[1] || !ptr_q)): gnt_o = 2'b01;
      (req_i[1] && (!req_i[0] ||  ptr_q)): gnt_o = 2'b10;
      default: ;
    endcase
  end

  // After a grant the other port becomes favoured.
  always_comb begin
    ptr_d = ptr_q;
    if (|gnt_o) ptr_d = ~gnt_o[1];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) ptr_q <= 1'b0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/shift_arbiter.sv
// Arbitrates two issue ports onto the shared registered shifter
// and returns each result to its owner via a one-entry buffer.
module shift_arbiter
  import shift_arbiter_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [DATA_W-1:0] req_opA0,
  input  logic [DATA_W-1:0] req_opA1,
  input  logic [DATA_W-1:0] req_opB0,
  input  logic [DATA_W-1:0] req_opB1,
  input  instruction_type   req_op0,
  input  instruction_type   req_op1,
  output logic [DATA_W-1:0] shf_opA,
  output logic [DATA_W-1:0] shf_opB,
  output instruction_type   shf_op,
  input  logic [DATA_W-1:0] shf_result,
  output logic [NREQ-1:0]   rsp_valid,
  input  logic [NREQ-1:0]   rsp_ready,
  output logic [DATA_W-1:0] rsp_data0,
  output logic [DATA_W-1:0] rsp_data1
);

  logic [NREQ-1:0]   elig;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   rsp_hs;
  logic              acc;
  req_id_t           acc_id;

  logic [NREQ-1:0]   outstanding_q;
  logic [NREQ-1:0]   outstanding_d;
  logic [NREQ-1:0]   rsp_valid_q;
  logic [NREQ-1:0]   rsp_valid_d;
  logic [DATA_W-1:0] rsp_data0_q;
  logic [DATA_W-1:0] rsp_data0_d;
  logic [DATA_W-1:0] rsp_data1_q;
  logic [DATA_W-1:0] rsp_data1_d;

  logic [SHIFT_LAT-1:0]    inflight_v_q;
  logic [SHIFT_LAT-1:0]    inflight_v_d;
  req_id_t [SHIFT_LAT-1:0] inflight_id_q;
  req_id_t [SHIFT_LAT-1:0] inflight_id_d;

  logic    cap_v;
  req_id_t cap_id;

  assign rsp_hs = rsp_valid_q & rsp_ready;

  // A port may reissue the cycle its previous result drains.
  assign elig = {NREQ{rstn}} & req_valid
              & (~outstanding_q | rsp_hs);

  rr_arb2 u_arb (
    .clk   (clk),
    .rstn  (rstn),
    .req_i (elig),
    .gnt_o (gnt)
  );

  assign req_ready = gnt;
  assign acc       = |gnt;
  assign acc_id    = gnt[1];

  always_comb begin
    shf_opA = '0;
    shf_opB = '0;
    shf_op  = OP0;
    unique case (1'b1)
      gnt[0]: begin
        shf_opA = req_opA0;
        shf_opB = req_opB0;
        shf_op  = req_op0;
      end
      gnt[1]: begin
        shf_opA = req_opA1;
        shf_opB = req_opB1;
        shf_op  = req_op1;
      end
      default: ;
    endcase
  end

  // Owner tag travels alongside the shifter pipeline.
  always_comb begin
    inflight_v_d  = SHIFT_LAT'({inflight_v_q, acc});
    inflight_id_d = SHIFT_LAT'({inflight_id_q, acc_id});
  end

  assign cap_v  = inflight_v_q[SHIFT_LAT-1];
  assign cap_id = inflight_id_q[SHIFT_LAT-1];

  always_comb begin
    outstanding_d = (outstanding_q & ~rsp_hs) | gnt;
    rsp_valid_d   = rsp_valid_q & ~rsp_hs;
    rsp_data0_d   = rsp_hs[0] ? '0 : rsp_data0_q;
    rsp_data1_d   = rsp_hs[1] ? '0 : rsp_data1_q;
    if (cap_v) begin
      rsp_valid_d[cap_id] = 1'b1;
      if (cap_id) rsp_data1_d = shf_result;
      else        rsp_data0_d = shf_result;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      outstanding_q <= '0;
      rsp_valid_q   <= '0;
      rsp_data0_q   <= '0;
      rsp_data1_q   <= '0;
      inflight_v_q  <= '0;
      inflight_id_q <= '0;
    end else begin
      outstanding_q <= outstanding_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data0_q   <= rsp_data0_d;
      rsp_data1_q   <= rsp_data1_d;
      inflight_v_q  <= inflight_v_d;
      inflight_id_q <= inflight_id_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data0 = rsp_data0_q;
  assign rsp_data1 = rsp_data1_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Scoreboard bench for shift_arbiter with a behavioural
// one-cycle shifter standing in for the shared datapath.
module tb_shift_arbiter;
  import shift_arbiter_pkg::*;

  typedef struct {
    logic [31:0]     a;
    logic [31:0]     b;
    instruction_type op;
  } req_t;

  typedef struct {
    logic [31:0] data;
    int          cyc;
    bit          seen;
  } exp_t;

  logic            clk;
  logic            rstn;
  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  logic [31:0]     req_opA0, req_opA1;
  logic [31:0]     req_opB0, req_opB1;
  instruction_type req_op0, req_op1;
  logic [31:0]     shf_opA, shf_opB;
  instruction_type shf_op;
  logic [31:0]     shf_result;
  logic [1:0]      rsp_valid;
  logic [1:0]      rsp_ready;
  logic [31:0]     rsp_data0, rsp_data1;

  req_t        src_q [2][$];
  exp_t        exp_q [2][$];
  logic [31:0] last_rsp [2];
  int          cyc;
  int          checks;
  int          fails;

  shift_arbiter #(.DATA_W(32)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_opA0   (req_opA0),
    .req_opA1   (req_opA1),
    .req_opB0   (req_opB0),
    .req_opB1   (req_opB1),
    .req_op0    (req_op0),
    .req_op1    (req_op1),
    .shf_opA    (shf_opA),
    .shf_opB    (shf_opB),
    .shf_op     (shf_op),
    .shf_result (shf_result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data0  (rsp_data0),
    .rsp_data1  (rsp_data1)
  );

  function automatic logic [31:0] ref_shift(
    logic [31:0] a, logic [31:0] b, instruction_type op);
    case (op)
      OP0:     return a << b[4:0];
      OP1:     return a >> b[4:0];
      default: return 32'($signed(a) >>> b[4:0]);
    endcase
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h (cyc %0d)",
               tag, obs, exp, cyc);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk)
    shf_result <= ref_shift(shf_opA, shf_opB, shf_op);

  // Request sources: hold the queue head until accepted.
  initial begin
    req_valid = '0;
    req_opA0 = '0; req_opB0 = '0; req_op0 = OP0;
    req_opA1 = '0; req_opB1 = '0; req_op1 = OP0;
    forever begin
      @(posedge clk);
      #1;
      if (src_q[0].size() > 0) begin
        req_valid[0] = 1'b1;
        req_opA0 = src_q[0][0].a;
        req_opB0 = src_q[0][0].b;
        req_op0  = src_q[0][0].op;
      end else begin
        req_valid[0] = 1'b0;
        req_opA0 = '0; req_opB0 = '0; req_op0 = OP0;
      end
      if (src_q[1].size() > 0) begin
        req_valid[1] = 1'b1;
        req_opA1 = src_q[1][0].a;
        req_opB1 = src_q[1][0].b;
        req_op1  = src_q[1][0].op;
      end else begin
        req_valid[1] = 1'b0;
        req_opA1 = '0; req_opB1 = '0; req_op1 = OP0;
      end
    end
  end

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (!rstn) begin
      exp_q[0].delete();
      exp_q[1].delete();
    end else begin
      chk("ready_onehot", 32'($countones(req_ready) <= 1), 32'd1);
      for (int i = 0; i < 2; i++) begin
        logic [31:0] d;
        d = (i == 1) ? rsp_data1 : rsp_data0;
        if (rsp_valid[i]) begin
          if (exp_q[i].size() == 0) begin
            chk("rsp_spurious", 32'(rsp_valid[i]), 32'd0);
          end else begin
            exp_t e;
            e = exp_q[i][0];
            if (!e.seen) begin
              chk("rsp_latency", 32'(cyc - e.cyc),
                  32'(SHIFT_LAT + 1));
              e.seen = 1'b1;
              exp_q[i][0] = e;
            end
            chk("rsp_data", d, e.data);
            if (rsp_ready[i]) begin
              last_rsp[i] = d;
              void'(exp_q[i].pop_front());
            end
          end
        end
        if (req_valid[i] && req_ready[i] && src_q[i].size() > 0) begin
          req_t r;
          exp_t n;
          r = src_q[i][0];
          chk("shf_opA", shf_opA, r.a);
          chk("shf_opB", shf_opB, r.b);
          chk("shf_op", 32'(shf_op), 32'(r.op));
          n.data = ref_shift(r.a, r.b, r.op);
          n.cyc  = cyc;
          n.seen = 1'b0;
          exp_q[i].push_back(n);
          void'(src_q[i].pop_front());
        end
      end
      if (!(|(req_valid & req_ready))) begin
        chk("idle_opA", shf_opA, 32'd0);
        chk("idle_op", 32'(shf_op), 32'(OP0));
      end
    end
  end

  task automatic push(input int p, input logic [31:0] a,
                      input logic [31:0] b, input instruction_type op);
    req_t r;
    r.a = a; r.b = b; r.op = op;
    src_q[p].push_back(r);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((src_q[0].size() + src_q[1].size() +
            exp_q[0].size() + exp_q[1].size()) != 0 && n < 80) begin
      @(negedge clk);
      n++;
    end
    if (n >= 80) chk("idle_timeout", 32'(n), 32'd0);
  endtask

  task automatic reset_dut();
    @(posedge clk);
    #3 rstn = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #3 rstn = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int acc0;
    checks = 0;
    fails = 0;
    cyc = 0;
    rstn = 1'b0;
    rsp_ready = 2'b11;
    last_rsp[0] = '0;
    last_rsp[1] = '0;

    // Reset values with a request already waiting.
    push(0, 32'h0000_0001, 32'h0000_0004, OP0);
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data0", rsp_data0, 32'd0);
    chk("rst_rsp_data1", rsp_data1, 32'd0);
    chk("rst_shf_opA", shf_opA, 32'd0);
    chk("rst_shf_opB", shf_opB, 32'd0);
    chk("rst_shf_op", 32'(shf_op), 32'(OP0));
    @(posedge clk);
    #3 rstn = 1'b1;
    @(negedge clk);
    chk("t1_ready", 32'(req_ready), 32'h1);
    wait_idle();
    chk("t1_data", last_rsp[0], 32'h0000_0010);

    // Tie after reset: port 0 first, then port 1.
    reset_dut();
    push(0, 32'h8000_0000, 32'd31, OP1);
    push(1, 32'h8000_0000, 32'd31, OP2);
    @(negedge clk);
    chk("t2_ready_p0", 32'(req_ready), 32'h1);
    chk("t2_op_p0", 32'(shf_op), 32'(OP1));
    @(negedge clk);
    chk("t2_ready_p1", 32'(req_ready), 32'h2);
    chk("t2_op_p1", 32'(shf_op), 32'(OP2));
    wait_idle();
    chk("t2_data0", last_rsp[0], 32'h0000_0001);
    chk("t2_data1", last_rsp[1], 32'hFFFF_FFFF);

    // Only opB[4:0] matters.
    push(0, 32'hF000_0000, 32'hFFFF_FFE3, OP2);
    wait_idle();
    chk("t3_data", last_rsp[0], 32'hFE00_0000);

    // Back-pressure on port 1 while port 0 streams.
    reset_dut();
    rsp_ready = 2'b01;
    push(1, 32'h1234_5678, 32'd4, OP0);
    push(1, 32'h0000_00F0, 32'd4, OP1);
    for (int j = 0; j < 6; j++)
      push(0, 32'(j + 1), 32'd1, OP0);
    acc0 = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (req_valid[0] && req_ready[0]) acc0++;
      if (k >= 2) chk("bp_ready1", 32'(req_ready[1]), 32'd0);
      if (k >= 3) chk("bp_hold", 32'(rsp_valid[1]), 32'd1);
    end
    chk("bp_p0_accepts", 32'(acc0), 32'd5);
    chk("bp_data1", rsp_data1, 32'h2345_6780);
    rsp_ready = 2'b11;
    wait_idle();
    chk("bp_last1", last_rsp[1], 32'h0000_000F);

    // Continuous port 0: accept and handshake coincide.
    for (int j = 0; j < 5; j++)
      push(0, 32'h0000_0100, 32'(j), OP1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("cont_acc", 32'(req_valid[0] && req_ready[0]),
          32'(k % 2 == 0));
      if (k > 0 && k % 2 == 0)
        chk("cont_hs", 32'(rsp_valid[0] && rsp_ready[0]), 32'd1);
      if (k > 0)
        chk("cont_outstanding", 32'(dut.outstanding_q[0]), 32'd1);
    end
    wait_idle();
    chk("cont_last", last_rsp[0], 32'h0000_0010);

    // Reset the cycle after an accept: result discarded.
    reset_dut();
    push(0, 32'h0000_0005, 32'd1, OP0);
    @(negedge clk);
    chk("t7_accept", 32'(req_ready), 32'h1);
    @(posedge clk);
    #3 rstn = 1'b0;
    repeat (2) @(negedge clk);
    chk("t7_rst_valid", 32'(rsp_valid), 32'd0);
    @(posedge clk);
    #3 rstn = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t7_no_stale", 32'(rsp_valid), 32'd0);
    end
    push(0, 32'h0000_0003, 32'd2, OP0);
    push(1, 32'h0000_0003, 32'd1, OP0);
    @(negedge clk);
    chk("t7_ptr_reset", 32'(req_ready), 32'h1);
    wait_idle();
    chk("t7_data0", last_rsp[0], 32'h0000_000C);
    chk("t7_data1", last_rsp[1], 32'h0000_0006);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
